// File: rtl/jtpopeye_objscan.sv
// Per-line sprite scanner: walks the 64-entry object RAM once per line and
// packs the objects that cover the next scanline into the back line-buffer bank.
module jtpopeye_objscan #(
    parameter int OBJ_H  = 16,
    parameter int MAXSPR = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        H0_cen,
    input  logic        line_start,
    input  logic [7:0]  V,
    output logic [5:0]  obj_addr,
    input  logic [28:0] obj_data,
    output logic        buf_we,
    output logic [5:0]  buf_addr,
    output logic [17:0] buf_din,
    output logic        bank,
    output logic        busy,
    output logic [6:0]  count,
    output logic        ovf
);

    typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;

    // Rows beyond the sprite height never reach the line buffer.
    localparam logic [3:0] ROW_MASK = (OBJ_H >= 16) ? 4'hF : 4'(OBJ_H - 1);
    localparam logic [8:0] OBJ_H9   = 9'(OBJ_H);
    localparam logic [6:0] MAX7     = 7'(MAXSPR);

    state_t      r_state, w_state_nxt;
    logic        r_pending;
    logic [5:0]  r_idx;
    logic [5:0]  r_obj_addr;
    logic        r_buf_we;
    logic [5:0]  r_buf_addr;
    logic [17:0] r_buf_din;
    logic        r_bank;
    logic [6:0]  r_count;
    logic        r_ovf;

    logic        w_start;
    logic [7:0]  w_y;
    logic [7:0]  w_dy;
    logic [3:0]  w_row;
    logic        w_hit;
    logic        w_room;
    logic        w_unused;

    assign w_start  = r_pending | line_start;
    assign w_y      = obj_data[15:8];
    assign w_dy     = V + 8'd1 - w_y;
    assign w_hit    = (w_y != 8'd0) && ({1'b0, w_dy} < OBJ_H9);
    assign w_row    = (w_dy[3:0] ^ {4{obj_data[27]}}) & ROW_MASK;
    assign w_room   = r_count < MAX7;
    assign w_unused = &{1'b0, obj_data[7:1]};

    // A start seen between enables is held until the enable that acts on it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else if (H0_cen) begin
            r_pending <= 1'b0;
        end else if (line_start) begin
            r_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        if (H0_cen) begin
            if (w_start) begin
                w_state_nxt = FETCH;
            end else begin
                case (r_state)
                    FETCH:   w_state_nxt = EVAL;
                    EVAL:    w_state_nxt = (r_idx == 6'd63) ? DONE : FETCH;
                    default: w_state_nxt = r_state;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= 6'd0;
            r_obj_addr <= 6'd0;
            r_buf_we   <= 1'b0;
            r_buf_addr <= 6'd0;
            r_buf_din  <= 18'd0;
            r_bank     <= 1'b0;
            r_count    <= 7'd0;
            r_ovf      <= 1'b0;
        end else if (H0_cen) begin
            r_buf_we <= 1'b0;
            if (w_start) begin
                r_bank  <= ~r_bank;
                r_idx   <= 6'd0;
                r_count <= 7'd0;
                r_ovf   <= 1'b0;
            end else begin
                case (r_state)
                    FETCH: r_obj_addr <= r_idx;
                    EVAL: begin
                        if (w_hit) begin
                            if (w_room) begin
                                r_buf_we   <= 1'b1;
                                r_buf_addr <= r_count[5:0];
                                r_buf_din  <= {obj_data[28:24], obj_data[23:16], w_row, obj_data[0]};
                                r_count    <= r_count + 7'd1;
                            end else begin
                                r_ovf <= 1'b1;
                            end
                        end
                        if (r_idx != 6'd63) r_idx <= r_idx + 6'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign obj_addr = r_obj_addr;
    assign buf_we   = r_buf_we;
    assign buf_addr = r_buf_addr;
    assign buf_din  = r_buf_din;
    assign bank     = r_bank;
    assign busy     = (r_state == FETCH) || (r_state == EVAL);
    assign count    = r_count;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_jtpopeye_objscan.sv
// Directed bench for jtpopeye_objscan: two instances (64 and 8 slots) share the
// stimulus; expected line-buffer writes are queued up front and matched as they commit.
module tb_jtpopeye_objscan;

    typedef struct {
        logic [5:0]  addr;
        logic [17:0] din;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        H0_cen;
    logic        line_start;
    logic [7:0]  V;
    logic [28:0] mem [64];

    logic [5:0]  obj_addr_64, obj_addr_8;
    logic [28:0] obj_data_64, obj_data_8;
    logic        buf_we_64, buf_we_8;
    logic [5:0]  buf_addr_64, buf_addr_8;
    logic [17:0] buf_din_64, buf_din_8;
    logic        bank_64, bank_8;
    logic        busy_64, busy_8;
    logic [6:0]  count_64, count_8;
    logic        ovf_64, ovf_8;

    exp_t q64[$];
    exp_t q8[$];
    exp_t e64, e8;
    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_bank;
    int   scan_len;

    assign obj_data_64 = mem[obj_addr_64];
    assign obj_data_8  = mem[obj_addr_8];

    jtpopeye_objscan #(.OBJ_H(16), .MAXSPR(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .H0_cen(H0_cen), .line_start(line_start), .V(V),
        .obj_addr(obj_addr_64), .obj_data(obj_data_64), .buf_we(buf_we_64),
        .buf_addr(buf_addr_64), .buf_din(buf_din_64), .bank(bank_64),
        .busy(busy_64), .count(count_64), .ovf(ovf_64)
    );

    jtpopeye_objscan #(.OBJ_H(16), .MAXSPR(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .H0_cen(H0_cen), .line_start(line_start), .V(V),
        .obj_addr(obj_addr_8), .obj_data(obj_data_8), .buf_we(buf_we_8),
        .buf_addr(buf_addr_8), .buf_din(buf_din_8), .bank(bank_8),
        .busy(busy_8), .count(count_8), .ovf(ovf_8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Enable every other clock, moved just after the rising edge.
    initial begin
        H0_cen = 1'b0;
        forever begin
            @(posedge clk);
            #1 H0_cen = ~H0_cen;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Committed writes are those with buf_we and H0_cen both high at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && H0_cen && buf_we_64) begin
            if (q64.size() == 0) begin
                check("sb64_unexpected_write", q64.size(), 1);
            end else begin
                e64 = q64.pop_front();
                check("sb64_addr", buf_addr_64, e64.addr);
                check("sb64_din", buf_din_64, e64.din);
            end
        end
        if (rst_n && H0_cen && buf_we_8) begin
            if (q8.size() == 0) begin
                check("sb8_unexpected_write", q8.size(), 1);
            end else begin
                e8 = q8.pop_front();
                check("sb8_addr", buf_addr_8, e8.addr);
                check("sb8_din", buf_din_8, e8.din);
            end
        end
    end

    function automatic logic [28:0] obj_word(input logic [5:0] i);
        logic [7:0] y;
        y = 8'h41 - {4'b0, i[3:0]};
        return {i[4:0], 2'b00, i, y, 7'b0, i[0]};
    endfunction

    // Entry i at V=0x40 sits at dy=i[3:0], flipped when attr bit 3 (i[3]) is set.
    function automatic logic [17:0] model_din(input logic [5:0] i);
        logic [3:0] r;
        r = i[3:0] ^ {4{i[3]}};
        return {i[4:0], 2'b00, i, r, i[0]};
    endfunction

    task automatic push_both(input logic [5:0] a, input logic [17:0] d);
        exp_t e;
        e.addr = a;
        e.din  = d;
        q64.push_back(e);
        q8.push_back(e);
    endtask

    task automatic push_entries(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = 6'(i);
            e.din  = model_din(6'(i));
            q64.push_back(e);
            if (i < 8) q8.push_back(e);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 29'd0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        exp_bank = ~exp_bank;
    endtask

    task automatic measure_scan(output int len);
        int guard;
        len = 0;
        guard = 0;
        while (!busy_64 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        guard = 0;
        while (busy_64 && guard < 1000) begin
            if (H0_cen) len++;
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic end_checks(input string tag, input int c64, input logic o64,
                              input int c8, input logic o8);
        check({tag, "_count64"}, count_64, c64);
        check({tag, "_ovf64"}, ovf_64, o64);
        check({tag, "_count8"}, count_8, c8);
        check({tag, "_ovf8"}, ovf_8, o8);
        check({tag, "_bank"}, bank_64, exp_bank);
        check({tag, "_busy"}, busy_64, 0);
        check({tag, "_buf_we"}, buf_we_64, 0);
        check({tag, "_left64"}, q64.size(), 0);
        check({tag, "_left8"}, q8.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_obj_addr"}, obj_addr_64, 0);
        check({tag, "_buf_we"}, buf_we_64, 0);
        check({tag, "_buf_addr"}, buf_addr_64, 0);
        check({tag, "_buf_din"}, buf_din_64, 0);
        check({tag, "_bank"}, bank_64, 0);
        check({tag, "_busy"}, busy_64, 0);
        check({tag, "_count"}, count_64, 0);
        check({tag, "_ovf"}, ovf_64, 0);
        check({tag, "_buf_we8"}, buf_we_8, 0);
    endtask

    initial begin
        int guard;
        rst_n      = 1'b0;
        line_start = 1'b0;
        V          = 8'h00;
        exp_bank   = 1'b0;
        clear_mem();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("reset");

        // Empty object RAM: full-length scan, no writes.
        V = 8'h1F;
        pulse_start();
        measure_scan(scan_len);
        check("empty_scan_len", scan_len, 128);
        end_checks("empty", 0, 1'b0, 0, 1'b0);

        // Entry 5 at dy=8, no flip.
        mem[5] = 29'h0342_1801;
        push_both(6'd0, 18'h06851);
        pulse_start();
        measure_scan(scan_len);
        check("hit_scan_len", scan_len, 128);
        end_checks("hit", 1, 1'b0, 1, 1'b0);
        check("hit_din_hold", buf_din_64, 18'h06851);

        // Same entry with vertical flip: row 7.
        mem[5] = 29'h0B42_1801;
        push_both(6'd0, 18'h1684F);
        pulse_start();
        measure_scan(scan_len);
        end_checks("flip", 1, 1'b0, 1, 1'b0);

        // dy=16 is just out of range; buffer outputs hold.
        mem[5] = 29'h0342_1001;
        pulse_start();
        measure_scan(scan_len);
        end_checks("dy16", 0, 1'b0, 0, 1'b0);
        check("dy16_din_hold", buf_din_64, 18'h1684F);

        // Wrapped distance: Y=0xF8 at V=7 is dy=16, Y=0xF9 is dy=15.
        V = 8'h07;
        mem[5] = 29'h0342_F801;
        pulse_start();
        measure_scan(scan_len);
        end_checks("wrap16", 0, 1'b0, 0, 1'b0);

        mem[5] = 29'h1155_F900;
        push_both(6'd0, 18'h22ABE);
        pulse_start();
        measure_scan(scan_len);
        end_checks("wrap15", 1, 1'b0, 1, 1'b0);

        // Every entry in range: 64-slot instance fills, 8-slot instance overflows.
        V = 8'h40;
        for (int i = 0; i < 64; i++) mem[i] = obj_word(6'(i));
        push_entries(64);
        pulse_start();
        measure_scan(scan_len);
        check("full_scan_len", scan_len, 128);
        end_checks("full", 64, 1'b0, 8, 1'b1);
        check("full_last_addr", buf_addr_64, 63);

        // Restart around entry 30 of a scan with hits in entries 0..9.
        clear_mem();
        for (int i = 0; i < 10; i++) mem[i] = obj_word(6'(i));
        push_entries(10);
        push_entries(10);
        pulse_start();
        guard = 0;
        while (!busy_64 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        repeat (120) @(negedge clk);
        check("abort_pre_count64", count_64, 10);
        check("abort_pre_ovf8", ovf_8, 1);
        @(negedge clk);
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        exp_bank = ~exp_bank;
        guard = 0;
        while (bank_64 !== exp_bank && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("abort_bank", bank_64, exp_bank);
        check("abort_count64", count_64, 0);
        check("abort_count8", count_8, 0);
        check("abort_ovf8", ovf_8, 0);
        check("abort_busy", busy_64, 1);
        repeat (2) @(negedge clk);
        check("abort_obj_addr", obj_addr_64, 0);
        measure_scan(scan_len);
        end_checks("abort", 10, 1'b0, 8, 1'b1);

        // Asynchronous reset while a write is pending.
        clear_mem();
        mem[0] = obj_word(6'd0);
        pulse_start();
        guard = 0;
        while (!buf_we_64 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("rst_saw_we", buf_we_64, 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        exp_bank = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_both(6'd0, model_din(6'd0));
        pulse_start();
        measure_scan(scan_len);
        check("recover_scan_len", scan_len, 128);
        end_checks("recover", 1, 1'b0, 1, 1'b0);
        check("recover_bank1", bank_64, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jtpopeye_objscan.md
Name: jtpopeye_objscan

Overview:
Per-line sprite scan controller that fills the ping-pong sprite line buffer. At every line start it walks the 64-entry object RAM, checks each entry against the next scanline, and writes in-range entries into consecutive slots of the back bank. It sits between the object RAM/DMA copy and the line-buffer RAMs. It owns bank selection, write addressing and overflow detection for that buffer.

Parameters:
OBJ_H, 16, sprite height in lines (power of two, 8..32)
MAXSPR, 64, slots per bank (1..64); hits beyond this are dropped

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
H0_cen  input  1  clock enable; all state advances only when high
line_start  input  1  one-clk pulse at the start of each line (HB falling)
V  input  8  current vertical count
obj_addr  output  6  object RAM read address
obj_data  input  29  object RAM read data, valid one H0_cen after obj_addr
buf_we  output  1  line-buffer write enable; qualify with H0_cen
buf_addr  output  6  line-buffer slot address
buf_din  output  18  line-buffer write data
bank  output  1  back bank being written; the front bank is ~bank
busy  output  1  scan in progress
count  output  7  hits written this line, saturates at MAXSPR
ovf  output  1  more than MAXSPR hits this line; sticky until the next start

Behaviour:
- Reset: state IDLE, obj_addr=0, buf_we=0, buf_addr=0, buf_din=0, bank=0, busy=0, count=0, ovf=0.
- Async reset mid-scan: immediate return to the reset values. No partial write is completed.
- line_start is sampled on any clk edge, independent of H0_cen. It is latched as pending until the next H0_cen.
- At the H0_cen that consumes a pending start:
  - bank toggles.
  - idx=0, count=0, ovf=0.
  - state becomes FETCH.
  - This happens from any state. A start arriving during a scan aborts that scan and restarts it.
- States: IDLE, FETCH, EVAL, DONE.
- FETCH, on H0_cen: obj_addr=idx, go to EVAL. busy=1 in FETCH and EVAL.
- EVAL, on H0_cen (obj_data valid): compute the hit.
  - Y=obj_data[15:8].
  - dy=(V+1-Y) mod 256, computed as 8-bit wrap.
  - hit = (Y!=0) && (dy < OBJ_H).
- EVAL on a hit with count<MAXSPR:
  - Drive buf_we=1, buf_addr=count[5:0] and buf_din for exactly one H0_cen period.
  - Then increment count.
- EVAL on a hit with count==MAXSPR: set ovf=1, no write, count stays.
- EVAL exit: if idx==63, go to DONE; otherwise idx++ and go to FETCH.
- Scan duration: 2 H0_cen per entry, 128 H0_cen per line, independent of the hit count.
- buf_din = { obj_data[28:24], obj_data[23:16], row[3:0], obj_data[0] }.
  - row = dy[3:0] ^ {4{obj_data[27]}} (vertical flip).
  - Bits of row above log2(OBJ_H) are forced to 0.
- DONE: busy=0, buf_we=0. Outputs hold until the next start.
- IDLE: behaves like DONE; it is only left on a start.
- buf_we is 0 in every state except the EVAL write period.
- buf_addr and buf_din keep their last value when buf_we=0.
- V is sampled once per EVAL. Callers hold V stable for the line.

Test Plan:
- Reset → all outputs 0. Single line_start with all entries Y=0 → bank=1, busy high for exactly 128 H0_cen, count=0, no buf_we pulse, ovf=0.
- V=0x1F; entry 5 Y=0x18, code 0x42, attr 0x03, bit27=0 → one write at buf_addr=0: dy=8, row=8, buf_din={5'h03,8'h42,4'h8,bit0}. count=1.
- Same entry with bit27=1 → row=7. Y=0x10 (dy=16) → no write. Y=0xF8 at V=0x07 (wrap, dy=16) → no write. Y=0xF9 → dy=15, write.
- All 64 entries in range with MAXSPR=64 → 64 writes, buf_addr 0..63, count=64, ovf=0. Rerun with MAXSPR=8 → 8 writes, count=8, ovf=1.
- line_start at entry 30 of a scan → bank toggles, count and ovf clear, obj_addr restarts at 0, no write to slot 0 occurs before the new EVAL.
- rst_n low during EVAL with a pending write → buf_we drops immediately, all reset values restored. Recovery on the next line_start is normal and bank is 1 after it.
